// File: rtl/vga_capture.sv
// vga_capture: VGA timing sink. Checks hsync/vsync/valid timing against the
// expected raster, locks after LOCK_FRAMES clean frames, then recovers pixel
// coordinates, strobes captured pixels out and keeps a per-frame checksum.
module vga_capture #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        valid,
  input  logic [23:0] vga_data,
  output logic        locked,
  output logic        pix_we,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [23:0] pix_data,
  output logic        frame_done,
  output logic [31:0] frame_sum,
  output logic [7:0]  err_cnt
);

  localparam logic [11:0] H_TOT  = 12'(H_TOTAL);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [10:0] V_TOT  = 11'(V_TOTAL);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    HUNT,
    ALIGN,
    LOCKED
  } state_e;

  state_e      state_q, state_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [11:0] hcnt_q, hcnt_d;
  logic [11:0] vldcnt_q, vldcnt_d;
  logic [10:0] line_cnt_q, line_cnt_d;
  logic [10:0] act_lines_q, act_lines_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic        bad_q, bad_d;
  logic [31:0] sum_q, sum_d;
  logic [31:0] frame_sum_q, frame_sum_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        frame_done_q, frame_done_d;
  logic        pix_we_q, pix_we_d;
  logic [9:0]  pix_x_q, pix_x_d;
  logic [8:0]  pix_y_q, pix_y_d;
  logic [23:0] pix_data_q, pix_data_d;

  logic        le, fe;
  logic [11:0] line_vld;
  logic [10:0] line_upd, act_upd;
  logic [31:0] sum_nxt;
  logic        pix_ok, chk_err, err_now;
  logic [3:0]  good_inc;

  // Timing checks, counters, capture, checksum and lock FSM next-state.
  always_comb begin
    hs_d = hsync;
    vs_d = vsync;
    le   = hs_q & ~hsync;
    fe   = vs_q & ~vsync;

    // A valid on the line-end cycle still belongs to the line being closed;
    // line_upd/act_upd fold that line in so a coincident FE checks it too.
    line_vld = (valid && vldcnt_q != '1) ? vldcnt_q + 12'd1 : vldcnt_q;
    act_upd  = (le && line_vld != '0 && act_lines_q != '1) ? act_lines_q + 11'd1 : act_lines_q;
    line_upd = (le && line_cnt_q != '1) ? line_cnt_q + 11'd1 : line_cnt_q;
    pix_ok   = (vldcnt_q < H_ACT) && (act_lines_q < V_ACT);

    chk_err = 1'b0;
    if (le && hcnt_q != H_TOT - 12'd1)                  chk_err = 1'b1;
    if (le && line_vld != '0 && line_vld != H_ACT)      chk_err = 1'b1;
    if (fe && (line_upd != V_TOT || act_upd != V_ACT))  chk_err = 1'b1;
    if (valid && !pix_ok)                               chk_err = 1'b1;
    err_now = chk_err && (state_q != HUNT);

    hcnt_d      = le ? '0 : ((hcnt_q != '1) ? hcnt_q + 12'd1 : hcnt_q);
    vldcnt_d    = le ? '0 : line_vld;
    line_cnt_d  = fe ? '0 : line_upd;
    act_lines_d = fe ? '0 : act_upd;

    sum_nxt     = sum_q + (valid ? {8'h00, vga_data} : 32'h0);
    sum_d       = fe ? '0 : sum_nxt;
    frame_sum_d = fe ? sum_nxt : frame_sum_q;

    bad_d        = fe ? 1'b0 : (bad_q | err_now);
    err_cnt_d    = (err_now && err_cnt_q != '1) ? err_cnt_q + 8'd1 : err_cnt_q;
    frame_done_d = fe && (state_q == LOCKED) && !err_now;

    pix_we_d   = 1'b0;
    pix_x_d    = pix_x_q;
    pix_y_d    = pix_y_q;
    pix_data_d = pix_data_q;
    if (state_q == LOCKED && valid && pix_ok) begin
      pix_we_d   = 1'b1;
      pix_x_d    = vldcnt_q[9:0];
      pix_y_d    = act_lines_q[8:0];
      pix_data_d = vga_data;
    end

    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    good_inc   = good_cnt_q + 4'd1;
    case (state_q)
      HUNT: begin
        if (fe) begin
          state_d    = ALIGN;
          good_cnt_d = '0;
        end
      end
      ALIGN: begin
        if (fe) begin
          if (!bad_q && !err_now) begin
            good_cnt_d = good_inc;
            if (good_inc >= LOCK_N) state_d = LOCKED;
          end else begin
            good_cnt_d = '0;
          end
        end
      end
      LOCKED: begin
        if (err_now) begin
          state_d    = HUNT;
          good_cnt_d = '0;
        end
      end
      default: begin
        state_d    = HUNT;
        good_cnt_d = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q      <= HUNT;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      hcnt_q       <= '0;
      vldcnt_q     <= '0;
      line_cnt_q   <= '0;
      act_lines_q  <= '0;
      good_cnt_q   <= '0;
      bad_q        <= 1'b0;
      sum_q        <= '0;
      frame_sum_q  <= '0;
      err_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      pix_we_q     <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      hcnt_q       <= hcnt_d;
      vldcnt_q     <= vldcnt_d;
      line_cnt_q   <= line_cnt_d;
      act_lines_q  <= act_lines_d;
      good_cnt_q   <= good_cnt_d;
      bad_q        <= bad_d;
      sum_q        <= sum_d;
      frame_sum_q  <= frame_sum_d;
      err_cnt_q    <= err_cnt_d;
      frame_done_q <= frame_done_d;
      pix_we_q     <= pix_we_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_data_q   <= pix_data_d;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign pix_we     = pix_we_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_data   = pix_data_q;
  assign frame_done = frame_done_q;
  assign frame_sum  = frame_sum_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: directed bench for vga_capture on a scaled-down raster
// (24 x 10 total, 8 x 6 active) so that many frames fit in a short run.
module tb_vga_capture;
  localparam int HT  = 24;  // cycles per line
  localparam int HSW = 4;   // hsync low width
  localparam int HX0 = 6;   // first valid column
  localparam int HA  = 8;   // active pixels per line
  localparam int VT  = 10;  // lines per frame
  localparam int VSW = 2;   // vsync low width in lines
  localparam int VY0 = 2;   // first active line
  localparam int VA  = 6;   // active lines

  logic        pclk = 1'b0;
  logic        reset, hsync, vsync, valid;
  logic [23:0] vga_data;
  logic        locked, pix_we, frame_done;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [23:0] pix_data;
  logic [31:0] frame_sum;
  logic [7:0]  err_cnt;

  vga_capture #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2)
  ) dut (
    .pclk(pclk), .reset(reset), .hsync(hsync), .vsync(vsync), .valid(valid),
    .vga_data(vga_data), .locked(locked), .pix_we(pix_we), .pix_x(pix_x),
    .pix_y(pix_y), .pix_data(pix_data), .frame_done(frame_done),
    .frame_sum(frame_sum), .err_cnt(err_cnt)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Frame generator configuration.
  int          bad_line, bad_len, vld_line, vld_cnt, probe_line, rst_line, data_mode;
  logic [23:0] const_data;

  // Per-frame observations.
  int          mark, done_mark, we_cnt, done_cnt, first_vld_cyc;
  logic        lock_pre_fe, lock_post_fe, probe_lock_pre, probe_lock_post;
  logic [7:0]  probe_err_pre, probe_err_post;
  logic [85:0] rst_snap;

  // Monitor: owns the running strobe/pulse totals.
  int          we_total = 0;
  int          done_total = 0;
  int          first_we_cyc;
  int          first_x, first_y, last_x, last_y;
  logic [23:0] first_data, last_data;
  always @(negedge pclk) begin
    if (pix_we) begin
      if (we_total == mark) begin
        first_x = int'(pix_x); first_y = int'(pix_y);
        first_data = pix_data; first_we_cyc = cyc;
      end
      last_x = int'(pix_x); last_y = int'(pix_y); last_data = pix_data;
      we_total++;
    end
    if (frame_done) done_total++;
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic cfg_clear();
    bad_line = -1; bad_len = HT; vld_line = -1; vld_cnt = HA;
    probe_line = -1; rst_line = -1; data_mode = 1; const_data = 24'h0;
  endtask

  task automatic run_frame();
    int len, lim, vcount;
    mark = we_total; done_mark = done_total; first_vld_cyc = -1;
    for (int l = 0; l < VT; l++) begin
      len = (l == bad_line) ? bad_len : HT;
      lim = (l == vld_line) ? vld_cnt : HA;
      vcount = 0;
      for (int c = 0; c < len; c++) begin
        hsync = (c >= HSW);
        vsync = (l >= VSW);
        valid = (l >= VY0) && (l < VY0 + VA) && (c >= HX0) && (vcount < lim);
        if (valid) vcount++;
        vga_data = (data_mode != 0) ? {8'hA5, 8'(l), 8'(c)} : const_data;
        if (valid && first_vld_cyc < 0) first_vld_cyc = cyc;
        reset = (l == rst_line) && (c == 10);
        if (l == 0 && c == 0) lock_pre_fe = locked;
        if (l == probe_line && c == 0) begin
          probe_lock_pre = locked; probe_err_pre = err_cnt;
        end
        step();
        if (l == 0 && c == 0) lock_post_fe = locked;
        if (l == probe_line && c == 0) begin
          probe_lock_post = locked; probe_err_post = err_cnt;
        end
        if (reset) begin
          rst_snap = {locked, pix_we, pix_x, pix_y, pix_data, frame_done, frame_sum, err_cnt};
          reset = 1'b0;
        end
      end
    end
    we_cnt   = we_total - mark;
    done_cnt = done_total - done_mark;
  endtask

  task automatic test_reset();
    reset = 1'b1; hsync = 1'b1; vsync = 1'b1; valid = 1'b0; vga_data = 24'h0;
    mark = 0; done_mark = 0;
    repeat (3) step();
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %0b want 0", locked); end
    tests++; if (pix_we !== 1'b0) begin fails++; $display("FAIL reset_pix_we: got %0b want 0", pix_we); end
    tests++; if (err_cnt !== 8'h0) begin fails++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    tests++; if ({pix_x, pix_y, pix_data, frame_done, frame_sum} !== 76'h0) begin
      fails++; $display("FAIL reset_outputs: got %0h want 0", {pix_x, pix_y, pix_data, frame_done, frame_sum});
    end
    reset = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_lock();
    cfg_clear();
    run_frame();
    tests++; if (lock_post_fe !== 1'b0) begin fails++; $display("FAIL lock_fe1: got %0b want 0", lock_post_fe); end
    run_frame();
    tests++; if (lock_post_fe !== 1'b0) begin fails++; $display("FAIL lock_fe2: got %0b want 0", lock_post_fe); end
    run_frame();
    tests++; if (lock_pre_fe !== 1'b0) begin fails++; $display("FAIL lock_pre_fe3: got %0b want 0", lock_pre_fe); end
    tests++; if (lock_post_fe !== 1'b1) begin fails++; $display("FAIL lock_fe3: got %0b want 1", lock_post_fe); end
    tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL lock_err_cnt: got %0d want 0", err_cnt); end
    tests++; if (we_cnt !== 48) begin fails++; $display("FAIL lock_frame3_strobes: got %0d want 48", we_cnt); end
  endtask

  task automatic test_capture();
    cfg_clear();
    run_frame();
    tests++; if (we_cnt !== 48) begin fails++; $display("FAIL cap_strobes: got %0d want 48", we_cnt); end
    tests++; if (first_x !== 0 || first_y !== 0) begin
      fails++; $display("FAIL cap_first_xy: got (%0d,%0d) want (0,0)", first_x, first_y);
    end
    tests++; if (first_data !== 24'hA50206) begin fails++; $display("FAIL cap_first_data: got %h want a50206", first_data); end
    tests++; if (first_we_cyc !== first_vld_cyc + 1) begin
      fails++; $display("FAIL cap_latency: got cycle %0d want %0d", first_we_cyc, first_vld_cyc + 1);
    end
    tests++; if (last_x !== 7 || last_y !== 5) begin
      fails++; $display("FAIL cap_last_xy: got (%0d,%0d) want (7,5)", last_x, last_y);
    end
    tests++; if (last_data !== 24'hA5070D) begin fails++; $display("FAIL cap_last_data: got %h want a5070d", last_data); end
    tests++; if (pix_x !== 10'd7 || pix_y !== 9'd5) begin
      fails++; $display("FAIL cap_hold_xy: got (%0d,%0d) want (7,5)", pix_x, pix_y);
    end
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL cap_frame_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_checksum();
    cfg_clear();
    data_mode = 0; const_data = 24'h123456;
    run_frame();
    cfg_clear();
    run_frame();
    // 48 pixels * 0x123456 = 0x0369D020
    tests++; if (frame_sum !== 32'h0369D020) begin fails++; $display("FAIL sum_const: got %h want 0369d020", frame_sum); end
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL sum_frame_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_long_line();
    cfg_clear();
    bad_line = 4; bad_len = HT + 1; probe_line = 5;
    run_frame();
    tests++; if (probe_err_pre !== 8'd0 || probe_err_post !== 8'd1) begin
      fails++; $display("FAIL long_err_cnt: got %0d->%0d want 0->1", probe_err_pre, probe_err_post);
    end
    tests++; if (probe_lock_pre !== 1'b1 || probe_lock_post !== 1'b0) begin
      fails++; $display("FAIL long_unlock: got %0b->%0b want 1->0", probe_lock_pre, probe_lock_post);
    end
    tests++; if (we_cnt !== 24) begin fails++; $display("FAIL long_strobes: got %0d want 24", we_cnt); end
    cfg_clear();
    run_frame();
    tests++; if (lock_post_fe !== 1'b0 || we_cnt !== 0 || done_cnt !== 0) begin
      fails++; $display("FAIL long_fe1: got lock=%0b we=%0d done=%0d want 0/0/0", lock_post_fe, we_cnt, done_cnt);
    end
    run_frame();
    tests++; if (lock_post_fe !== 1'b0 || we_cnt !== 0) begin
      fails++; $display("FAIL long_fe2: got lock=%0b we=%0d want 0/0", lock_post_fe, we_cnt);
    end
    run_frame();
    tests++; if (lock_pre_fe !== 1'b0 || lock_post_fe !== 1'b1) begin
      fails++; $display("FAIL long_relock: got %0b->%0b want 0->1", lock_pre_fe, lock_post_fe);
    end
    tests++; if (we_cnt !== 48 || err_cnt !== 8'd1) begin
      fails++; $display("FAIL long_after: got we=%0d err=%0d want 48/1", we_cnt, err_cnt);
    end
  endtask

  task automatic test_short_line();
    cfg_clear();
    vld_line = 3; vld_cnt = HA - 1; probe_line = 4;
    run_frame();
    tests++; if (probe_err_pre !== 8'd1 || probe_err_post !== 8'd2) begin
      fails++; $display("FAIL short_err_cnt: got %0d->%0d want 1->2", probe_err_pre, probe_err_post);
    end
    tests++; if (probe_lock_pre !== 1'b1 || probe_lock_post !== 1'b0) begin
      fails++; $display("FAIL short_unlock: got %0b->%0b want 1->0", probe_lock_pre, probe_lock_post);
    end
    tests++; if (we_cnt !== 15 || done_cnt !== 1) begin
      fails++; $display("FAIL short_frame: got we=%0d done=%0d want 15/1", we_cnt, done_cnt);
    end
    cfg_clear();
    run_frame();
    tests++; if (done_cnt !== 0 || lock_post_fe !== 1'b0) begin
      fails++; $display("FAIL short_done_suppressed: got done=%0d lock=%0b want 0/0", done_cnt, lock_post_fe);
    end
    run_frame();
    tests++; if (lock_post_fe !== 1'b0 || done_cnt !== 0) begin
      fails++; $display("FAIL short_fe2: got lock=%0b done=%0d want 0/0", lock_post_fe, done_cnt);
    end
    run_frame();
    tests++; if (lock_pre_fe !== 1'b0 || lock_post_fe !== 1'b1 || err_cnt !== 8'd2) begin
      fails++; $display("FAIL short_relock: got %0b->%0b err=%0d want 0->1 err=2", lock_pre_fe, lock_post_fe, err_cnt);
    end
  endtask

  task automatic test_extra_valid();
    cfg_clear();
    vld_line = 2; vld_cnt = HA + 1;
    run_frame();
    tests++; if (we_cnt !== 8) begin fails++; $display("FAIL extra_strobes: got %0d want 8", we_cnt); end
    tests++; if (err_cnt !== 8'd3 || locked !== 1'b0) begin
      fails++; $display("FAIL extra_error: got err=%0d lock=%0b want 3/0", err_cnt, locked);
    end
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL extra_prev_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    cfg_clear();
    rst_line = 4;
    run_frame();
    tests++; if (rst_snap !== 86'h0) begin fails++; $display("FAIL midrst_outputs: got %0h want 0", rst_snap); end
    tests++; if (err_cnt !== 8'd0 || locked !== 1'b0) begin
      fails++; $display("FAIL midrst_after: got err=%0d lock=%0b want 0/0", err_cnt, locked);
    end
    cfg_clear();
    run_frame();
    tests++; if (lock_post_fe !== 1'b0) begin fails++; $display("FAIL midrst_fe1: got %0b want 0", lock_post_fe); end
    run_frame();
    tests++; if (lock_post_fe !== 1'b0) begin fails++; $display("FAIL midrst_fe2: got %0b want 0", lock_post_fe); end
    run_frame();
    tests++; if (lock_pre_fe !== 1'b0 || lock_post_fe !== 1'b1 || err_cnt !== 8'd0) begin
      fails++; $display("FAIL midrst_relock: got %0b->%0b err=%0d want 0->1 err=0", lock_pre_fe, lock_post_fe, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_capture();
    test_checksum();
    test_long_line();
    test_short_line();
    test_extra_valid();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
